// File: rtl/addr_decoder_pkg.sv
// Shared constants for the CPU address decoder:
// memory port indices, region selects and the IO address map.
package addr_decoder_pkg;

  localparam int BRAM_PROG_ROM = 0;
  localparam int BRAM_PROG_RAM = 1;
  localparam int BRAM_VECTOR   = 2;
  localparam int BRAM_MATH     = 3;
  localparam int BRAM_POKEY    = 4;
  localparam int BRAM_N        = 5;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PROG_ROM,
    SEL_PROG_RAM,
    SEL_VECTOR,
    SEL_MATH,
    SEL_POKEY,
    SEL_IO
  } sel_t;

  localparam logic [15:0] PROG_RAM_LO = 16'h0000;
  localparam logic [15:0] PROG_RAM_HI = 16'h07FF;
  localparam logic [15:0] ADDR_IN0    = 16'h0800;
  localparam logic [15:0] ADDR_DSW0   = 16'h0A00;
  localparam logic [15:0] ADDR_DSW1   = 16'h0C00;
  localparam logic [15:0] ADDR_VGGO   = 16'h1200;
  localparam logic [15:0] ADDR_VGRST  = 16'h1600;
  localparam logic [15:0] ADDR_MSTAT  = 16'h1800;
  localparam logic [15:0] ADDR_BTNS   = 16'h1808;
  localparam logic [15:0] MATH_RD_LO  = 16'h1810;
  localparam logic [15:0] MATH_RD_HI  = 16'h181F;
  localparam logic [15:0] POKEY_LO    = 16'h1820;
  localparam logic [15:0] POKEY_HI    = 16'h182F;
  localparam logic [15:0] MATH_WR_LO  = 16'h1860;
  localparam logic [15:0] MATH_WR_HI  = 16'h187F;
  localparam logic [15:0] VECTOR_LO   = 16'h2000;
  localparam logic [15:0] VECTOR_HI   = 16'h3FFF;
  localparam logic [15:0] PROG_ROM_LO = 16'h4000;
  localparam logic [15:0] PROG_ROM_HI = 16'h7FFF;

  function automatic logic in_range(
    input logic [15:0] a,
    input logic [15:0] lo,
    input logic [15:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/addr_decoder.sv
// CPU address decoder: memory port fan-out, IO reads,
// vector generator strobes and the read-data return mux.
module addr_decoder
  import addr_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [15:0]      addr,
  input  logic             we,
  input  logic [7:0]       dataFromCore,
  input  logic [4:0][7:0]  dataFromBram,
  input  logic             halt,
  input  logic             clk_3KHz,
  input  logic             self_test,
  input  logic             coin,
  input  logic [7:0]       DSW0,
  input  logic [7:0]       DSW1,
  input  logic [7:0]       REDBARONBUTTONS,
  input  logic             mod_redbaron,
  output logic [7:0]       dataToCore,
  output logic [4:0][15:0] addrToBram,
  output logic [4:0][7:0]  dataToBram,
  output logic [4:0]       weEnBram,
  output logic             vggo,
  output logic             vgrst
);

  sel_t       sel_d;
  sel_t       sel_q;
  logic [7:0] io_d;
  logic [7:0] data_q;
  logic [7:0] in0;

  // diag, slam and aux switches are not fitted and read inactive
  assign in0 = {clk_3KHz, halt, 1'b1, ~self_test,
                1'b1, 1'b1, 1'b1, ~coin};

  always_comb begin
    sel_d = SEL_NONE;
    io_d  = 8'hFF;
    unique case (1'b1)
      in_range(addr, PROG_RAM_LO, PROG_RAM_HI):
        sel_d = SEL_PROG_RAM;
      in_range(addr, MATH_RD_LO, MATH_RD_HI):
        sel_d = SEL_MATH;
      in_range(addr, POKEY_LO, POKEY_HI):
        sel_d = SEL_POKEY;
      in_range(addr, VECTOR_LO, VECTOR_HI):
        sel_d = SEL_VECTOR;
      in_range(addr, PROG_ROM_LO, PROG_ROM_HI):
        sel_d = SEL_PROG_ROM;
      addr == ADDR_IN0: begin
        sel_d = SEL_IO;
        io_d  = in0;
      end
      addr == ADDR_DSW0: begin
        sel_d = SEL_IO;
        io_d  = DSW0;
      end
      addr == ADDR_DSW1: begin
        sel_d = SEL_IO;
        io_d  = DSW1;
      end
      addr == ADDR_MSTAT: begin
        sel_d = SEL_IO;
        io_d  = 8'h00;
      end
      addr == ADDR_BTNS: begin
        sel_d = SEL_IO;
        io_d  = mod_redbaron ? REDBARONBUTTONS : 8'hFF;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < BRAM_N; i++) begin
      addrToBram[i] = addr;
      dataToBram[i] = dataFromCore;
    end
  end

  always_comb begin
    weEnBram = '0;
    weEnBram[BRAM_PROG_RAM] =
      we & in_range(addr, PROG_RAM_LO, PROG_RAM_HI);
    weEnBram[BRAM_VECTOR] =
      we & in_range(addr, VECTOR_LO, VECTOR_HI);
    weEnBram[BRAM_MATH] =
      we & in_range(addr, MATH_WR_LO, MATH_WR_HI);
    weEnBram[BRAM_POKEY] =
      we & in_range(addr, POKEY_LO, POKEY_HI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= SEL_NONE;
      data_q <= 8'hFF;
      vggo   <= 1'b0;
      vgrst  <= 1'b0;
    end else begin
      vggo  <= clk_en & we & (addr == ADDR_VGGO);
      vgrst <= clk_en & we & (addr == ADDR_VGRST);
      if (clk_en) begin
        sel_q  <= sel_d;
        data_q <= io_d;
      end
    end
  end

  always_comb begin
    dataToCore = 8'hFF;
    unique case (sel_q)
      SEL_PROG_ROM: dataToCore = dataFromBram[BRAM_PROG_ROM];
      SEL_PROG_RAM: dataToCore = dataFromBram[BRAM_PROG_RAM];
      SEL_VECTOR:   dataToCore = dataFromBram[BRAM_VECTOR];
      SEL_MATH:     dataToCore = dataFromBram[BRAM_MATH];
      SEL_POKEY:    dataToCore = dataFromBram[BRAM_POKEY];
      SEL_IO:       dataToCore = data_q;
      default:      dataToCore = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_addr_decoder.sv
// Directed bench for addr_decoder: decode table plus
// strobe, hold and reset sequences.
module tb_addr_decoder;

  logic             clk = 1'b0;
  logic             rst;
  logic             clk_en;
  logic [15:0]      addr;
  logic             we;
  logic [7:0]       dataFromCore;
  logic [4:0][7:0]  dataFromBram;
  logic             halt;
  logic             clk_3KHz;
  logic             self_test;
  logic             coin;
  logic [7:0]       DSW0;
  logic [7:0]       DSW1;
  logic [7:0]       REDBARONBUTTONS;
  logic             mod_redbaron;
  logic [7:0]       dataToCore;
  logic [4:0][15:0] addrToBram;
  logic [4:0][7:0]  dataToBram;
  logic [4:0]       weEnBram;
  logic             vggo;
  logic             vgrst;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  addr_decoder dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .addr(addr), .we(we), .dataFromCore(dataFromCore),
    .dataFromBram(dataFromBram), .halt(halt),
    .clk_3KHz(clk_3KHz), .self_test(self_test),
    .coin(coin), .DSW0(DSW0), .DSW1(DSW1),
    .REDBARONBUTTONS(REDBARONBUTTONS),
    .mod_redbaron(mod_redbaron),
    .dataToCore(dataToCore), .addrToBram(addrToBram),
    .dataToBram(dataToBram), .weEnBram(weEnBram),
    .vggo(vggo), .vgrst(vgrst)
  );

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [7:0]  wd;
    logic        mrb;
    logic [7:0]  rd;
    logic [4:0]  wen;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name,
                       input logic [79:0] act,
                       input logic [79:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b0;
    addr = 16'h0000;
    we = 1'b0;
    dataFromCore = 8'h00;
    dataFromBram = {8'h44, 8'h33, 8'h22, 8'h11, 8'h4C};
    halt = 1'b1;
    clk_3KHz = 1'b0;
    self_test = 1'b1;
    coin = 1'b1;
    DSW0 = 8'h5A;
    DSW1 = 8'h96;
    REDBARONBUTTONS = 8'h3C;
    mod_redbaron = 1'b1;

    tv.push_back('{16'h0123, 1'b0, 8'h00, 1'b1, 8'h11, 5'b00000});
    tv.push_back('{16'h0123, 1'b1, 8'hA5, 1'b1, 8'h11, 5'b00010});
    tv.push_back('{16'h07FF, 1'b0, 8'h00, 1'b1, 8'h11, 5'b00000});
    tv.push_back('{16'h0800, 1'b0, 8'h00, 1'b1, 8'h6E, 5'b00000});
    tv.push_back('{16'h0801, 1'b0, 8'h00, 1'b1, 8'hFF, 5'b00000});
    tv.push_back('{16'h0A00, 1'b0, 8'h00, 1'b1, 8'h5A, 5'b00000});
    tv.push_back('{16'h0C00, 1'b0, 8'h00, 1'b1, 8'h96, 5'b00000});
    tv.push_back('{16'h1000, 1'b1, 8'h12, 1'b1, 8'hFF, 5'b00000});
    tv.push_back('{16'h1800, 1'b0, 8'h00, 1'b1, 8'h00, 5'b00000});
    tv.push_back('{16'h1808, 1'b0, 8'h00, 1'b1, 8'h3C, 5'b00000});
    tv.push_back('{16'h1808, 1'b0, 8'h00, 1'b0, 8'hFF, 5'b00000});
    tv.push_back('{16'h1810, 1'b0, 8'h00, 1'b1, 8'h33, 5'b00000});
    tv.push_back('{16'h181F, 1'b1, 8'h77, 1'b1, 8'h33, 5'b00000});
    tv.push_back('{16'h1820, 1'b0, 8'h00, 1'b1, 8'h44, 5'b00000});
    tv.push_back('{16'h182F, 1'b1, 8'h3E, 1'b1, 8'h44, 5'b10000});
    tv.push_back('{16'h1860, 1'b1, 8'h01, 1'b1, 8'hFF, 5'b01000});
    tv.push_back('{16'h187F, 1'b1, 8'h02, 1'b1, 8'hFF, 5'b01000});
    tv.push_back('{16'h1880, 1'b1, 8'h03, 1'b1, 8'hFF, 5'b00000});
    tv.push_back('{16'h2000, 1'b0, 8'h00, 1'b1, 8'h22, 5'b00000});
    tv.push_back('{16'h3FFF, 1'b1, 8'hC3, 1'b1, 8'h22, 5'b00100});
    tv.push_back('{16'h5000, 1'b0, 8'h00, 1'b1, 8'h4C, 5'b00000});
    tv.push_back('{16'h5000, 1'b1, 8'h99, 1'b1, 8'h4C, 5'b00000});

    repeat (2) @(negedge clk);
    #1;
    check("reset dataToCore", 80'(dataToCore), 80'hFF);
    check("reset strobes", 80'({vggo, vgrst}), 80'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tv[i]) begin
      @(negedge clk);
      addr = tv[i].a;
      we = tv[i].w;
      dataFromCore = tv[i].wd;
      mod_redbaron = tv[i].mrb;
      clk_en = 1'b1;
      #1;
      check($sformatf("wen %h", tv[i].a),
            80'(weEnBram), 80'(tv[i].wen));
      check($sformatf("bram addr %h", tv[i].a),
            80'(addrToBram), {5{tv[i].a}});
      check($sformatf("bram data %h", tv[i].a),
            80'(dataToBram), 80'({5{tv[i].wd}}));
      @(negedge clk);
      clk_en = 1'b0;
      we = 1'b0;
      #1;
      check($sformatf("read %h", tv[i].a),
            80'(dataToCore), 80'(tv[i].rd));
    end
    mod_redbaron = 1'b1;

    // vggo: one clk wide even with clk_en held high
    @(negedge clk);
    addr = 16'h1200; we = 1'b1; clk_en = 1'b1;
    @(negedge clk);
    addr = 16'h0800; we = 1'b0;
    #1 check("vggo high", 80'({vggo, vgrst}), 80'h2);
    @(negedge clk);
    clk_en = 1'b0;
    #1 check("vggo low", 80'({vggo, vgrst}), 80'h0);
    check("in0 latched", 80'(dataToCore), 80'h6E);
    self_test = 1'b0;
    coin = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("hold without clk_en", 80'(dataToCore), 80'h6E);
    self_test = 1'b1;
    coin = 1'b1;

    @(negedge clk);
    addr = 16'h1600; we = 1'b1; clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0; we = 1'b0;
    #1 check("vgrst high", 80'({vggo, vgrst}), 80'h1);
    @(negedge clk);
    #1 check("vgrst low", 80'({vggo, vgrst}), 80'h0);

    @(negedge clk);
    addr = 16'h1400; we = 1'b1; clk_en = 1'b1;
    #1 check("watchdog wen", 80'(weEnBram), 80'h0);
    @(negedge clk);
    clk_en = 1'b0; we = 1'b0;
    #1 check("watchdog no pulse", 80'({vggo, vgrst}), 80'h0);

    // write strobe but no clk_en: no pulse
    @(negedge clk);
    addr = 16'h1200; we = 1'b1; clk_en = 1'b0;
    @(negedge clk);
    we = 1'b0;
    #1 check("vggo needs clk_en", 80'(vggo), 80'h0);

    // reset over a pending read and simultaneous vggo write
    @(negedge clk);
    addr = 16'h5000; we = 1'b0; clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    #1 check("pending rom read", 80'(dataToCore), 80'h4C);
    @(negedge clk);
    addr = 16'h1200; we = 1'b1; clk_en = 1'b1; rst = 1'b1;
    @(negedge clk);
    addr = 16'h0123; dataFromCore = 8'h5E;
    #1 check("rst dataToCore", 80'(dataToCore), 80'hFF);
    check("rst strobes", 80'({vggo, vgrst}), 80'h0);
    check("rst wen passthru", 80'(weEnBram), 80'h02);
    check("rst data passthru", 80'(dataToBram[1]), 80'h5E);
    @(negedge clk);
    rst = 1'b0; clk_en = 1'b0; we = 1'b0;
    #1 check("post rst hold", 80'(dataToCore), 80'hFF);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
